// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants and FSM state type.
// Used by fetch_stage, fetch_stage_if and fetch_stage_pc_register.
package fetch_stage_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned STATE_WIDTH = 2;
    localparam int unsigned STALL_CNT_W = 16;

    localparam logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0040_0000;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [STATE_WIDTH-1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard enables, redirects, imem port and IF/ID outputs.
// The fetch stage itself connects through the slave modport.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                   en_pc;
    logic                   en_ifid;
    logic                   branch_taken;
    logic [DATA_WIDTH-1:0]  branch_target;
    logic                   jump;
    logic [DATA_WIDTH-1:0]  jump_target;
    logic [DATA_WIDTH-1:0]  imem_addr;
    logic [DATA_WIDTH-1:0]  imem_rdata;
    logic [DATA_WIDTH-1:0]  ifid_pc4;
    logic [DATA_WIDTH-1:0]  ifid_instr;
    logic                   ifid_valid;
    logic [STATE_WIDTH-1:0] fetch_state;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output en_pc, en_ifid, branch_taken, branch_target, jump, jump_target, imem_rdata,
        input  imem_addr, ifid_pc4, ifid_instr, ifid_valid, fetch_state, stall_cycles
    );

    modport slave (
        input  en_pc, en_ifid, branch_taken, branch_target, jump, jump_target, imem_rdata,
        output imem_addr, ifid_pc4, ifid_instr, ifid_valid, fetch_state, stall_cycles
    );

endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter flop: async active-low reset, load has priority over increment.
module fetch_stage_pc_register
    import fetch_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  inc,
    output logic [DATA_WIDTH-1:0] pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + DATA_WIDTH'(4);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID pipeline register and fetch status FSM.
// Optional stall-cycle counter enabled by defining FETCH_STALL_COUNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);

    fetch_state_t          state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] ifid_pc4;
    logic [DATA_WIDTH-1:0] ifid_instr;
    logic                  ifid_valid;
    logic                  redirect_c;
    logic [DATA_WIDTH-1:0] target_c;
    logic                  active_c;

    // The branch is the older instruction, so it beats a same-cycle jump.
    assign redirect_c = bus.branch_taken | bus.jump;
    assign target_c   = bus.branch_taken ? bus.branch_target : bus.jump_target;
    assign active_c   = (state != BOOT);

    fetch_stage_pc_register u_pc (
        .clk        (clk),
        .reset      (reset),
        .load       (active_c & redirect_c),
        .load_value (target_c),
        .inc        (active_c & bus.en_pc),
        .pc         (pc)
    );

    // FSM and IF/ID register; a redirect flushes even when ID is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            ifid_pc4   <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (redirect_c)       state <= FLUSH;
                         else if (!bus.en_pc)  state <= STALL;
                STALL:   if (redirect_c)       state <= FLUSH;
                         else if (bus.en_pc)   state <= RUN;
                FLUSH:   if (redirect_c)       state <= FLUSH;
                         else if (!bus.en_pc)  state <= STALL;
                         else                  state <= RUN;
                default: state <= BOOT;
            endcase

            if (active_c) begin
                if (redirect_c) begin
                    ifid_pc4   <= '0;
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                end else if (bus.en_ifid) begin
                    ifid_pc4   <= pc + DATA_WIDTH'(4);
                    ifid_instr <= bus.imem_rdata;
                    ifid_valid <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Saturating count of cycles spent in STALL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if ((state == STALL) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = '0;
`endif

    assign bus.imem_addr   = pc;
    assign bus.ifid_pc4    = ifid_pc4;
    assign bus.ifid_instr  = ifid_instr;
    assign bus.ifid_valid  = ifid_valid;
    assign bus.fetch_state = state;

endmodule
